// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word-size encodings, word-length lookup and the
// receiver state type. The transmitter uses the same word_size encoding.
package i2s_pkg;

    localparam logic [1:0] WS_16 = 2'd0;
    localparam logic [1:0] WS_24 = 2'd1;
    localparam logic [1:0] WS_32 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RECV  = 2'd2
    } rx_state_t;

    // Code 3 is not a legal size and falls back to 16 bits.
    function automatic logic [5:0] ws_bits(input logic [1:0] word_size);
        logic [5:0] n;
        case (word_size)
            WS_24:   n = 6'd24;
            WS_32:   n = 6'd32;
            default: n = 6'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchroniser for one asynchronous pin plus a registered rising-edge pulse.
// The level output is delayed one extra flop so it lines up with the pulse.
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic              rise_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain  <= '0;
            prev   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            chain  <= {chain[STAGES-2:0], din};
            prev   <= chain[STAGES-1];
            rise_q <= chain[STAGES-1] & ~prev;
        end
    end

    assign level = prev;
    assign rise  = rise_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: aligns to the first left slot, deserialises MSB-first
// words and writes them as 16-bit beats into a FIFO with an active-low full.
module i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  word_size,
    input  logic        sck,
    input  logic        ws,
    input  logic        sd,
    output logic [15:0] data_out,
    output logic        data_ch,
    output logic        data_wr,
    input  logic        ff_n,
    input  logic        err_clr,
    output logic        overrun,
    output logic        frame_err
);

    logic sck_level_unused;
    logic ws_rise_unused;
    logic sd_rise_unused;
    logic sck_rise;
    logic ws_s;
    logic sd_s;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(sck), .level(sck_level_unused), .rise(sck_rise)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk(clk), .rst_n(rst_n), .din(ws), .level(ws_s), .rise(ws_rise_unused)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(clk), .rst_n(rst_n), .din(sd), .level(sd_s), .rise(sd_rise_unused)
    );

    rx_state_t   state_q;
    rx_state_t   state_d;
    logic        ws_last_q;
    logic [4:0]  bit_cnt_q;
    logic [4:0]  last_idx_q;
    logic [15:0] shreg_q;
    logic        ch_q;
    logic        done_q;
    logic        drop_q;

    logic [4:0]  last_sel;
    logic        ws_edge;
    logic        align_hit;
    logic        bit_take;
    logic [15:0] shift_nx;
    logic        two_beat;
    logic        at_mid;
    logic        word_end;
    logic        beat_hit;
    logic [15:0] beat_val;
    logic        emit;
    logic        new_overrun;
    logic        short_slot;

    assign last_sel  = 5'(ws_bits(word_size) - 6'd1);
    assign ws_edge   = sck_rise && (ws_s != ws_last_q);
    assign align_hit = (state_q == ST_ALIGN) && sck_rise && ws_last_q && !ws_s;
    assign bit_take  = (state_q == ST_RECV) && sck_rise && !done_q;
    assign shift_nx  = {shreg_q[14:0], sd_s};

    // The bit sampled on a ws-edge rise is still the LSB of the old slot.
    assign two_beat    = (last_idx_q != 5'd15);
    assign at_mid      = bit_take && two_beat && (bit_cnt_q == 5'd15);
    assign word_end    = bit_take && (bit_cnt_q == last_idx_q);
    assign beat_hit    = at_mid || word_end;
    assign beat_val    = (word_end && last_idx_q == 5'd23) ? {shift_nx[7:0], 8'h00} : shift_nx;
    assign emit        = beat_hit && ff_n && !(word_end && drop_q);
    assign new_overrun = beat_hit && !ff_n;
    assign short_slot  = ws_edge && (state_q == ST_RECV) && !done_q && !word_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_ALIGN;
            ST_ALIGN: if (align_hit) state_d = ST_RECV;
            ST_RECV:  state_d = ST_RECV;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_ch    <= 1'b0;
            data_wr    <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            ws_last_q  <= 1'b0;
            bit_cnt_q  <= '0;
            last_idx_q <= 5'd15;
            shreg_q    <= '0;
            ch_q       <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            data_wr   <= emit;
            overrun   <= (overrun & ~err_clr) | new_overrun;
            frame_err <= (frame_err & ~err_clr) | short_slot;
            if (emit) begin
                data_out <= beat_val;
                data_ch  <= ch_q;
            end
            if (state_q == ST_IDLE) begin
                last_idx_q <= last_sel;
            end
            if (sck_rise) begin
                ws_last_q <= ws_s;
            end
            // A new slot always restarts the word, complete or not.
            if (align_hit || (ws_edge && state_q == ST_RECV)) begin
                bit_cnt_q <= '0;
                ch_q      <= ws_s;
                done_q    <= 1'b0;
                drop_q    <= 1'b0;
            end else if (bit_take) begin
                shreg_q <= shift_nx;
                if (word_end) begin
                    done_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
                if (at_mid && !ff_n) begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

endmodule
